// File: rtl/cosinehw_core_if.sv
// Register-side bundle for the cosine engine: captured vectors and start in, status and result out.
// The master drives the vectors and start; the slave is the compute engine.
interface cosinehw_core_if #(
   parameter int RegWidth = 32
);
   logic [RegWidth-1:0] avec_i;
   logic [RegWidth-1:0] bvec_i;
   logic                start_i;
   logic                busy_o;
   logic [RegWidth-1:0] cos_o;
   logic                done_o;

   modport master (
      output avec_i, bvec_i, start_i,
      input  busy_o, cos_o, done_o
   );

   modport slave (
      input  avec_i, bvec_i, start_i,
      output busy_o, cos_o, done_o
   );
endinterface

// File: rtl/cosinehw_core.sv
// Cosine similarity of two packed signed vectors as Q1.15: MAC, sqrt, then divide; done 39 edges after start (6 if a vector is zero).
// No backpressure: start is only honoured in IDLE, and the result holds until the next accepted start.
module cosinehw_core #(
   parameter int RegWidth  = 32,
   parameter int ElemWidth = 8
) (
   input logic            clk_i,
   input logic            rst_ni,
   cosinehw_core_if.slave bus
);
   localparam int NumElems = RegWidth / ElemWidth;
   localparam int PW       = 2 * ElemWidth;

   typedef enum logic [2:0] {
      S_IDLE, S_MAC, S_NORM, S_SQRT, S_DIV, S_FIN
   } state_e;

   state_e state, state_nxt;

   logic [RegWidth-1:0] a_sh, b_sh;
   logic signed [17:0]  dot;
   logic [16:0]         na, nb;
   logic [33:0]         rad;
   logic [18:0]         srem;
   logic [16:0]         root;
   logic [16:0]         drem;
   logic [15:0]         dnum;
   logic [16:0]         q;
   logic                neg;
   logic [4:0]          cnt;
   logic [RegWidth-1:0] cos_q;
   logic                done_q;

   logic signed [ElemWidth-1:0] ae, be;
   logic signed [PW-1:0]        pab, paa, pbb;
   logic [33:0]                 p;
   logic signed [17:0]          dot_abs;
   logic [20:0]                 s_rem, s_trial;
   logic [18:0]                 s_diff;
   logic                        s_ge;
   logic [17:0]                 d_t;
   logic [16:0]                 d_diff;
   logic                        d_ge;
   logic [16:0]                 mag, res;

   always_comb begin
      ae      = a_sh[ElemWidth-1:0];
      be      = b_sh[ElemWidth-1:0];
      pab     = ae * be;
      paa     = ae * ae;
      pbb     = be * be;
      p       = 34'(na) * 34'(nb);
      dot_abs = dot[17] ? -dot : dot;
      // Square root: bring down two radicand bits, try subtracting 4*root+1.
      s_rem   = {srem, rad[33:32]};
      s_trial = {2'b00, root, 2'b01};
      s_ge    = (s_rem >= s_trial);
      s_diff  = s_rem[18:0] - s_trial[18:0];
      d_t     = {drem, dnum[15]};
      d_ge    = (d_t >= {1'b0, root});
      d_diff  = d_t[16:0] - root;
      mag     = (q > 17'd32767) ? (neg ? 17'd32768 : 17'd32767) : q;
      res     = neg ? -mag : mag;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (bus.start_i) state_nxt = S_MAC;
         S_MAC:  if (cnt == 5'(NumElems - 1)) state_nxt = S_NORM;
         S_NORM: state_nxt = (p == '0) ? S_FIN : S_SQRT;
         S_SQRT: if (cnt == 5'd16) state_nxt = S_DIV;
         S_DIV:  if (cnt == 5'd15) state_nxt = S_FIN;
         S_FIN:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         a_sh   <= '0;
         b_sh   <= '0;
         dot    <= '0;
         na     <= '0;
         nb     <= '0;
         rad    <= '0;
         srem   <= '0;
         root   <= '0;
         drem   <= '0;
         dnum   <= '0;
         q      <= '0;
         neg    <= 1'b0;
         cnt    <= '0;
         cos_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt <= (state_nxt != state) ? 5'd0 : cnt + 5'd1;
         case (state)
            S_IDLE: begin
               if (bus.start_i) begin
                  a_sh   <= bus.avec_i;
                  b_sh   <= bus.bvec_i;
                  dot    <= '0;
                  na     <= '0;
                  nb     <= '0;
                  done_q <= 1'b0;
               end
            end
            S_MAC: begin
               a_sh <= a_sh >> ElemWidth;
               b_sh <= b_sh >> ElemWidth;
               dot  <= dot + 18'(pab);
               na   <= na + 17'($unsigned(paa));
               nb   <= nb + 17'($unsigned(pbb));
            end
            S_NORM: begin
               rad  <= p;
               srem <= '0;
               root <= '0;
               neg  <= dot[17];
               // |dot| <= root, so the top 17 numerator bits are already below the divisor.
               drem <= dot_abs[17:1];
               dnum <= {dot_abs[0], 15'd0};
               q    <= '0;
            end
            S_SQRT: begin
               srem <= s_ge ? s_diff : s_rem[18:0];
               root <= {root[15:0], s_ge};
               rad  <= {rad[31:0], 2'b00};
            end
            S_DIV: begin
               drem <= d_ge ? d_diff : d_t[16:0];
               dnum <= {dnum[14:0], 1'b0};
               q    <= {q[15:0], d_ge};
            end
            S_FIN: begin
               cos_q  <= RegWidth'($signed(res));
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy_o = (state != S_IDLE);
   assign bus.cos_o  = cos_q;
   assign bus.done_o = done_q;
endmodule

// File: tb/tb_cosinehw_core.sv
// Bench for cosinehw_core: arithmetic reference model with a per-cycle compare, plus directed literal checks.
module tb_cosinehw_core;
   logic clk = 1'b0;
   logic rst_n;
   int   vec  = 0;
   int   errs = 0;

   cosinehw_core_if #(.RegWidth(32)) bus ();

   cosinehw_core #(.RegWidth(32), .ElemWidth(8)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic longint ref_norm_prod(input logic [31:0] a, input logic [31:0] b);
      longint na, nb, sa, sb;
      logic [7:0] ea, eb;
      na = 0;
      nb = 0;
      for (int i = 0; i < 4; i++) begin
         ea = a[8*i +: 8];
         eb = b[8*i +: 8];
         sa = $signed(ea);
         sb = $signed(eb);
         na += sa * sa;
         nb += sb * sb;
      end
      return na * nb;
   endfunction

   function automatic logic [31:0] ref_cos(input logic [31:0] a, input logic [31:0] b);
      longint dot, p, r, t, q, ad, sa, sb;
      logic [7:0] ea, eb;
      dot = 0;
      for (int i = 0; i < 4; i++) begin
         ea = a[8*i +: 8];
         eb = b[8*i +: 8];
         sa = $signed(ea);
         sb = $signed(eb);
         dot += sa * sb;
      end
      p = ref_norm_prod(a, b);
      if (p == 0) return 32'd0;
      r = 0;
      for (int k = 20; k >= 0; k--) begin
         t = r + (longint'(1) << k);
         if (t * t <= p) r = t;
      end
      ad = (dot < 0) ? -dot : dot;
      q  = (ad * 32768) / r;
      if (dot < 0) begin
         if (q > 32767) q = 32768;
         return 32'(-q);
      end
      if (q > 32767) q = 32767;
      return 32'(q);
   endfunction

   function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
      return (ref_norm_prod(a, b) == 0) ? 6 : 39;
   endfunction

   // Reference timeline: a run is a countdown from acceptance to the result.
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic [31:0] m_cos  = 32'd0;
   logic [31:0] m_pend = 32'd0;
   int          m_left = 0;
   bit          chk_en = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_cos  = 32'd0;
      end else if (!m_busy) begin
         if (bus.start_i) begin
            m_busy = 1'b1;
            m_done = 1'b0;
            m_pend = ref_cos(bus.avec_i, bus.bvec_i);
            m_left = ref_lat(bus.avec_i, bus.bvec_i);
         end
      end else begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_cos  = m_pend;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy_cycle", {31'd0, bus.busy_o}, {31'd0, m_busy});
         chk("done_cycle", {31'd0, bus.done_o}, {31'd0, m_done});
         chk("cos_cycle", bus.cos_o, m_cos);
      end
   end

   // Called at a negedge; starts immediately so consecutive calls are back-to-back.
   task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_cos,
                      input int exp_lat, input int pulse_at, input int chg_at, input int rst_at,
                      input string nm);
      int n;
      n = 0;
      bus.avec_i  = a;
      bus.bvec_i  = b;
      bus.start_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start_i = 1'b0;
      while (bus.done_o !== 1'b1 && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         bus.start_i = (n == pulse_at);
         if (n == chg_at) begin
            bus.avec_i = $urandom;
            bus.bvec_i = $urandom;
         end
         if (n == rst_at) begin
            rst_n = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk({nm, "_rst_busy"}, {31'd0, bus.busy_o}, 32'd0);
            chk({nm, "_rst_done"}, {31'd0, bus.done_o}, 32'd0);
            chk({nm, "_rst_cos"}, bus.cos_o, 32'd0);
            rst_n = 1'b1;
            return;
         end
      end
      bus.start_i = 1'b0;
      chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
      chk({nm, "_cos"}, bus.cos_o, exp_cos);
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.start_i = 1'b0;
      bus.avec_i  = 32'd0;
      bus.bvec_i  = 32'd0;

      chk("model_sat_pos", ref_cos(32'h01010101, 32'h01010101), 32'h00007FFF);
      chk("model_sat_neg", ref_cos(32'h01010101, 32'hFFFFFFFF), 32'hFFFF8000);
      chk("model_6666", ref_cos(32'h03000004, 32'h00000004), 32'h00006666);
      chk("model_4ccc", ref_cos(32'h00000304, 32'h00000400), 32'h00004CCC);
      chk("model_extreme", ref_cos(32'h80808080, 32'h7F7F7F7F), 32'hFFFF8000);
      chk("model_lat_zero", 32'(ref_lat(32'h0, 32'h12345678)), 32'd6);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", {31'd0, bus.busy_o}, 32'd0);
      chk("reset_done", {31'd0, bus.done_o}, 32'd0);
      chk("reset_cos", bus.cos_o, 32'd0);
      chk_en = 1'b1;
      rst_n  = 1'b1;
      @(negedge clk);

      run(32'h01010101, 32'h01010101, 32'h00007FFF, 39, -1, -1, -1, "ones");
      run(32'h01010101, 32'hFFFFFFFF, 32'hFFFF8000, 39, -1, -1, -1, "neg_b2b");
      run(32'h03000004, 32'h00000004, 32'h00006666, 39, -1, -1, -1, "frac");
      run(32'h01FF01FF, 32'h01010101, 32'h00000000, 39, -1, -1, -1, "ortho");
      run(32'h00000000, 32'h12345678, 32'h00000000, 6, -1, -1, -1, "zero");
      run(32'h00000304, 32'h00000400, 32'h00004CCC, 39, 10, -1, -1, "pulse_sqrt");
      run(32'h01010101, 32'h01010101, 32'h00000000, 39, -1, -1, 30, "abort_div");
      run(32'h00000304, 32'h00000400, 32'h00004CCC, 39, -1, -1, -1, "after_rst");
      run(32'h80808080, 32'h7F7F7F7F, 32'hFFFF8000, 39, -1, 2, -1, "extreme");

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
